// File: rtl/rv_pkg.sv
// Shared RV32I types: instruction-type encoding, fault causes and sequencer states.
package rv_pkg;

  typedef enum logic [3:0] {
    LOAD  = 4'd0,
    IMM   = 4'd1,
    STORE = 4'd2,
    REG   = 4'd3,
    LUI   = 4'd4,
    AUIPC = 4'd5,
    BRNCH = 4'd6,
    JALR  = 4'd7,
    JAL   = 4'd8
  } inst_type_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    ILLEGAL  = 2'd2
  } cause_e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pcs_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC target computation with misalignment and illegal-type detection.
module pc_target_calc
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      inst_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] r,
  input  logic            br_taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned,
  output logic            illegal
);

  // Select the target; only control-transfer targets can be misaligned.
  always_comb begin
    target     = pc + XLEN'(4);
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (inst_type)
      LOAD, IMM, STORE, REG, LUI, AUIPC: ;
      BRNCH: begin
        if (br_taken) begin
          target     = pc + imm;
          misaligned = |target[1:0];
        end
      end
      JALR: begin
        target     = (r + imm) & ~XLEN'(1);
        misaligned = |target[1:0];
      end
      JAL: begin
        target     = pc + imm;
        misaligned = |target[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC/EPC registers, RUN/FAULT FSM and retired counter.
module pc_sequencer
  import rv_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter int unsigned    CWORD_W      = 23,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned    CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CWORD_W-1:0] cword,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    r,
  input  logic               br_taken,
  input  logic               valid,
  input  logic               stall,
  input  logic               trap_req,
  input  logic               trap_ret,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    link,
  output logic [XLEN-1:0]    epc,
  output logic               fault,
  output logic [1:0]         cause,
  output logic [CNT_W-1:0]   instret
);

  pcs_state_e       state_q;
  logic [XLEN-1:0]  pc_q, epc_q;
  logic             fault_q;
  cause_e           cause_q;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0]  target;
  logic             misaligned, illegal;

  // Only the instruction-type field of the control word matters here.
  logic unused_cword;
  assign unused_cword = ^cword[CWORD_W-1:4];

  pc_target_calc #(
    .XLEN (XLEN)
  ) u_target (
    .inst_type  (cword[3:0]),
    .pc         (pc_q),
    .imm        (imm),
    .r          (r),
    .br_taken   (br_taken),
    .target     (target),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // FSM and state registers; FAULT redirects to the trap vector and ignores all requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      fault_q   <= 1'b0;
      cause_q   <= NONE;
      instret_q <= '0;
    end else begin
      unique case (state_q)
        FAULT: begin
          fault_q <= 1'b0;
          pc_q    <= TRAP_VECTOR;
          state_q <= RUN;
        end
        RUN: begin
          if (trap_req) begin
            epc_q <= pc_q;
            pc_q  <= TRAP_VECTOR;
          end else if (trap_ret) begin
            pc_q <= epc_q;
          end else if (!stall && valid) begin
            if (illegal || misaligned) begin
              epc_q   <= pc_q;
              cause_q <= illegal ? ILLEGAL : MISALIGN;
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              pc_q      <= target;
              instret_q <= instret_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc      = pc_q;
  assign link    = pc_q + XLEN'(4);
  assign epc     = epc_q;
  assign fault   = fault_q;
  assign cause   = cause_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table plus random run vs model.
module tb_pc_sequencer;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] cword;
  logic [31:0] imm, r;
  logic        br_taken, valid, stall, trap_req, trap_ret;
  logic [31:0] pc, link, epc, instret;
  logic        fault;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cword    (cword),
    .imm      (imm),
    .r        (r),
    .br_taken (br_taken),
    .valid    (valid),
    .stall    (stall),
    .trap_req (trap_req),
    .trap_ret (trap_ret),
    .pc       (pc),
    .link     (link),
    .epc      (epc),
    .fault    (fault),
    .cause    (cause),
    .instret  (instret)
  );

  typedef struct {
    logic [3:0]  typ;
    logic [31:0] imm;
    logic [31:0] r;
    logic        br;
    logic        valid;
    logic        stall;
    logic        treq;
    logic        tret;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic        e_fault;
    logic [1:0]  e_cause;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic e_fault, input logic [1:0] e_cause,
                         input logic [31:0] e_instret);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".link"}, link, e_pc + 32'd4);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
    chk({tag, ".cause"}, {30'd0, cause}, {30'd0, e_cause});
    chk({tag, ".instret"}, instret, e_instret);
  endtask

  task automatic add(input logic [3:0] typ, input logic [31:0] im, input logic [31:0] rr,
                     input logic br, input logic v, input logic st, input logic tq,
                     input logic tr, input logic [31:0] e_pc, input logic [31:0] e_epc,
                     input logic e_f, input logic [1:0] e_c, input logic [31:0] e_ic);
    vec_t x;
    x = '{typ, im, rr, br, v, st, tq, tr, e_pc, e_epc, e_f, e_c, e_ic};
    vecs.push_back(x);
  endtask

  task automatic drive(input logic [3:0] typ, input logic [31:0] im, input logic [31:0] rr,
                       input logic br, input logic v, input logic st, input logic tq,
                       input logic tr);
    cword    = {19'h5a5a5, typ};
    imm      = im;
    r        = rr;
    br_taken = br;
    valid    = v;
    stall    = st;
    trap_req = tq;
    trap_ret = tr;
  endtask

  // Reference model state (architectural view).
  logic [31:0] m_pc, m_epc, m_ic;
  logic [1:0]  m_cause;
  logic        m_fault;

  task automatic model_reset();
    m_pc = 32'd0; m_epc = 32'd0; m_ic = 32'd0; m_cause = 2'd0; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic rs, input logic [3:0] typ, input logic [31:0] im,
                            input logic [31:0] rr, input logic br, input logic v,
                            input logic st, input logic tq, input logic tr);
    logic [31:0] tgt;
    logic        bad_type, bad_align;
    if (rs) begin
      model_reset();
    end else if (m_fault) begin
      m_fault = 1'b0;
      m_pc    = TV;
    end else if (tq) begin
      m_epc = m_pc;
      m_pc  = TV;
    end else if (tr) begin
      m_pc = m_epc;
    end else if (!st && v) begin
      bad_type  = typ > 4'd8;
      tgt       = m_pc + 32'd4;
      bad_align = 1'b0;
      if (typ == 4'd6 && br) begin tgt = m_pc + im; bad_align = tgt % 4 != 0; end
      if (typ == 4'd7) begin tgt = (rr + im) / 2 * 2; bad_align = tgt % 4 != 0; end
      if (typ == 4'd8) begin tgt = m_pc + im; bad_align = tgt % 4 != 0; end
      if (bad_type || bad_align) begin
        m_epc   = m_pc;
        m_cause = bad_type ? 2'd2 : 2'd1;
        m_fault = 1'b1;
      end else begin
        m_pc = tgt;
        m_ic = m_ic + 32'd1;
      end
    end
  endtask

  initial begin
    // typ imm r br v st tq tr | pc epc fault cause instret
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 0, 32'd4,        32'd0,    0, 2'd0, 32'd1);
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 0, 32'd8,        32'd0,    0, 2'd0, 32'd2);
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 0, 32'd12,       32'd0,    0, 2'd0, 32'd3);
    add(4'd6, 32'd16,        32'd0, 1, 1, 0, 0, 0, 32'd28,       32'd0,    0, 2'd0, 32'd4);
    add(4'd8, 32'hFFFFFFF0,  32'd0, 0, 1, 0, 0, 0, 32'd12,       32'd0,    0, 2'd0, 32'd5);
    add(4'd6, 32'd16,        32'd0, 0, 1, 0, 0, 0, 32'd16,       32'd0,    0, 2'd0, 32'd6);
    add(4'd8, 32'hFFFFFFFC,  32'd0, 0, 1, 0, 0, 0, 32'd12,       32'd0,    0, 2'd0, 32'd7);
    add(4'd6, 32'd15,        32'd0, 1, 1, 0, 0, 0, 32'd12,       32'd12,   1, 2'd1, 32'd7);
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 0, TV,           32'd12,   0, 2'd1, 32'd7);
    add(4'd7, 32'd15,        32'd9, 0, 1, 0, 0, 0, 32'd24,       32'd12,   0, 2'd1, 32'd8);
    add(4'd7, 32'd13,        32'd9, 0, 1, 0, 0, 0, 32'd24,       32'd24,   1, 2'd1, 32'd8);
    add(4'd1, 32'd0,         32'd0, 0, 0, 0, 1, 0, TV,           32'd24,   0, 2'd1, 32'd8);
    add(4'd12, 32'd0,        32'd0, 0, 1, 0, 0, 0, TV,           TV,       1, 2'd2, 32'd8);
    add(4'd1, 32'd0,         32'd0, 0, 0, 0, 0, 0, TV,           TV,       0, 2'd2, 32'd8);
    add(4'd8, 32'hFFFFFF40,  32'd0, 0, 1, 0, 0, 0, 32'h40,       TV,       0, 2'd2, 32'd9);
    for (int i = 0; i < 4; i++)
      add(4'd1, 32'd0,       32'd0, 0, 1, 1, 0, 0, 32'h40,       TV,       0, 2'd2, 32'd9);
    add(4'd1, 32'd0,         32'd0, 0, 1, 1, 1, 0, TV,           32'h40,   0, 2'd2, 32'd9);
    add(4'd1, 32'd0,         32'd0, 0, 0, 0, 0, 1, 32'h40,       32'h40,   0, 2'd2, 32'd9);
    add(4'd1, 32'd0,         32'd0, 0, 0, 0, 1, 1, TV,           32'h40,   0, 2'd2, 32'd9);
    add(4'd8, 32'hFFFFFEFC,  32'd0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h40,   0, 2'd2, 32'd10);
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 0, 32'd0,        32'h40,   0, 2'd2, 32'd11);
    add(4'd1, 32'd0,         32'd0, 0, 0, 0, 0, 0, 32'd0,        32'h40,   0, 2'd2, 32'd11);
    add(4'd1, 32'd0,         32'd0, 0, 1, 0, 0, 1, 32'h40,       32'h40,   0, 2'd2, 32'd11);
    add(4'd2, 32'd0,         32'd0, 0, 1, 0, 0, 0, 32'h44,       32'h40,   0, 2'd2, 32'd12);

    // Reset for two cycles.
    drive(4'd1, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'd0, 32'd0, 0, 2'd0, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].typ, vecs[i].imm, vecs[i].r, vecs[i].br, vecs[i].valid, vecs[i].stall,
            vecs[i].treq, vecs[i].tret);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_epc, vecs[i].e_fault,
              vecs[i].e_cause, vecs[i].e_instret);
    end

    // Reset arriving during FAULT aborts the trap redirect.
    drive(4'd9, 32'd0, 32'd0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("illegal9", 32'h44, 32'h44, 1, 2'd2, 32'd12);
    rst = 1'b1;
    drive(4'd1, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_in_fault", 32'd0, 32'd0, 0, 2'd0, 32'd0);
    rst = 1'b0;

    // Random run against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        rs, br, v, st, tq, tr;
      logic [3:0]  typ;
      logic [31:0] im, rr;
      rs  = ($urandom_range(0, 199) == 0);
      typ = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      im  = ($urandom_range(0, 7) == 0) ? $urandom : {{24{1'b0}}, 6'($urandom), 2'b00} - 32'd128;
      rr  = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
      br  = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 5) == 0);
      tq  = ($urandom_range(0, 19) == 0);
      tr  = ($urandom_range(0, 19) == 0);
      rst = rs;
      drive(typ, im, rr, br, v, st, tq, tr);
      model_step(rs, typ, im, rr, br, v, st, tq, tr);
      @(posedge clk);
      #1;
      chk_all("rand", m_pc, m_epc, m_fault, m_cause, m_ic);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
